// File: rtl/hamming74_secded_dec_if.sv
// Handshake and status bundle for the Hamming(7,4) SECDED decoder.
// The slave modport is the decoder's view; the master modport is the surrounding logic's view.
interface hamming74_secded_dec_if #(
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [6:0]       i_hamming_code;
  logic             i_parity;
  logic             o_valid;
  logic             i_ready;
  logic [3:0]       o_data;
  logic             o_single_err;
  logic             o_double_err;
  logic [2:0]       o_err_pos;
  logic             i_cnt_clr;
  logic [CNT_W-1:0] o_sec_cnt;
  logic [CNT_W-1:0] o_ded_cnt;

  modport slave (
    input  i_valid, i_hamming_code, i_parity, i_ready, i_cnt_clr,
    output o_ready, o_valid, o_data, o_single_err, o_double_err, o_err_pos,
           o_sec_cnt, o_ded_cnt
  );

  modport master (
    output i_valid, i_hamming_code, i_parity, i_ready, i_cnt_clr,
    input  o_ready, o_valid, o_data, o_single_err, o_double_err, o_err_pos,
           o_sec_cnt, o_ded_cnt
  );
endinterface

// File: rtl/hamming74_secded_dec.sv
// Two-stage Hamming(7,4) SECDED decoder: stage 1 registers syndrome/parity, stage 2 the
// classified result. Valid/ready handshake with saturating single- and double-error counters.
module hamming74_secded_dec #(
  parameter int CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  hamming74_secded_dec_if.slave bus
);

  function automatic logic [6:0] flip_bit(input logic [6:0] c, input logic [2:0] s);
    logic [6:0] m;
    m = '0;
    if (s != 3'd0) m[s - 3'd1] = 1'b1;
    return c ^ m;
  endfunction

  function automatic logic [3:0] data_of(input logic [6:0] c);
    return {c[6], c[5], c[4], c[2]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic             vld_p1, vld_p2;
  logic [6:0]       code_p1;
  logic [2:0]       syn_p1;
  logic             perr_p1;
  logic [3:0]       data_p2;
  logic             sec_p2, ded_p2;
  logic [2:0]       pos_p2;
  logic [CNT_W-1:0] sec_cnt, ded_cnt;

  logic       adv, in_xfer, out_xfer;
  logic [2:0] syn_in;
  logic       perr_in;
  logic [3:0] nxt_data;
  logic       nxt_sec, nxt_ded;
  logic [2:0] nxt_pos;

  // Stage 2 frees up whenever it is empty or its word leaves this cycle.
  assign adv      = ~vld_p2 | bus.i_ready;
  assign in_xfer  = bus.i_valid & bus.o_ready;
  assign out_xfer = vld_p2 & bus.i_ready;

  always_comb begin
    syn_in[0] = bus.i_hamming_code[0] ^ bus.i_hamming_code[2] ^
                bus.i_hamming_code[4] ^ bus.i_hamming_code[6];
    syn_in[1] = bus.i_hamming_code[1] ^ bus.i_hamming_code[2] ^
                bus.i_hamming_code[5] ^ bus.i_hamming_code[6];
    syn_in[2] = bus.i_hamming_code[3] ^ bus.i_hamming_code[4] ^
                bus.i_hamming_code[5] ^ bus.i_hamming_code[6];
    perr_in   = (^bus.i_hamming_code) ^ bus.i_parity;
  end

  // ---- stage 1: code word, syndrome, overall parity ----
  always_ff @(posedge i_clk) begin
    if (in_xfer) begin
      code_p1 <= bus.i_hamming_code;
      syn_p1  <= syn_in;
      perr_p1 <= perr_in;
    end
  end

  // Parity mismatch means an odd error count (correctable); syndrome alone means double.
  always_comb begin
    nxt_data = perr_p1 ? data_of(flip_bit(code_p1, syn_p1)) : data_of(code_p1);
    nxt_sec  = perr_p1;
    nxt_ded  = ~perr_p1 & (syn_p1 != 3'd0);
    nxt_pos  = perr_p1 ? syn_p1 : 3'd0;
  end

  // ---- stage 2: classified result and counters ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      sec_p2  <= 1'b0;
      ded_p2  <= 1'b0;
      pos_p2  <= '0;
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      vld_p1 <= in_xfer | (vld_p1 & ~adv);
      if (adv) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          data_p2 <= nxt_data;
          sec_p2  <= nxt_sec;
          ded_p2  <= nxt_ded;
          pos_p2  <= nxt_pos;
        end
      end
      if (bus.i_cnt_clr) begin
        sec_cnt <= '0;
        ded_cnt <= '0;
      end else if (out_xfer) begin
        if (sec_p2) sec_cnt <= sat_inc(sec_cnt);
        if (ded_p2) ded_cnt <= sat_inc(ded_cnt);
      end
    end
  end

  assign bus.o_ready      = ~vld_p1 | ~vld_p2 | bus.i_ready;
  assign bus.o_valid      = vld_p2;
  assign bus.o_data       = data_p2;
  assign bus.o_single_err = sec_p2;
  assign bus.o_double_err = ded_p2;
  assign bus.o_err_pos    = pos_p2;
  assign bus.o_sec_cnt    = sec_cnt;
  assign bus.o_ded_cnt    = ded_cnt;

endmodule

// File: tb/tb_hamming74_secded_dec.sv
// Bench for hamming74_secded_dec: directed vector table, handshake corner sequences and a
// randomized run against an encode-and-inject reference model.
module tb_hamming74_secded_dec;
  localparam int CNT_W = 2;

  logic clk, rst;
  int n_tests = 0;
  int n_fail  = 0;

  hamming74_secded_dec_if #(.CNT_W(CNT_W)) bus ();
  hamming74_secded_dec #(.CNT_W(CNT_W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0] code;
    logic       par;
    logic [3:0] data;
    logic       sec;
    logic       ded;
    logic [2:0] pos;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic       sec;
    logic       ded;
    logic [2:0] pos;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Textbook encoder: parity at positions 1,2,4 covers every position sharing that bit.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    logic p;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    for (int pp = 1; pp <= 4; pp = pp * 2) begin
      p = 1'b0;
      for (int q = 1; q <= 7; q++)
        if (q != pp && (q & pp) != 0) p = p ^ c[q-1];
      c[pp-1] = p;
    end
    return c;
  endfunction

  // Expected decoder output from the number and location of injected flips.
  function automatic exp_t classify(input logic [3:0] d, input logic [7:0] mask,
                                    input logic [6:0] code);
    exp_t e;
    e.data = d; e.sec = 1'b0; e.ded = 1'b0; e.pos = 3'd0;
    if ($countones(mask) == 1) begin
      e.sec = 1'b1;
      for (int i = 0; i < 7; i++) if (mask[i]) e.pos = 3'(i + 1);
    end else if ($countones(mask) == 2) begin
      e.ded  = 1'b1;
      e.data = {code[6], code[5], code[4], code[2]};
    end
    return e;
  endfunction

  function automatic int sat3(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  vec_t vecs[8];
  int   exp_sec, exp_ded;

  initial begin
    vecs[0] = '{7'h55, 1'b0, 4'hB, 1'b0, 1'b0, 3'd0};
    vecs[1] = '{7'h45, 1'b0, 4'hB, 1'b1, 1'b0, 3'd5};
    vecs[2] = '{7'h56, 1'b0, 4'hB, 1'b0, 1'b1, 3'd0};
    vecs[3] = '{7'h55, 1'b1, 4'hB, 1'b1, 1'b0, 3'd0};
    vecs[4] = '{7'h00, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0};
    vecs[5] = '{7'h7F, 1'b1, 4'hF, 1'b0, 1'b0, 3'd0};
    vecs[6] = '{7'h54, 1'b0, 4'hB, 1'b1, 1'b0, 3'd1};
    vecs[7] = '{7'h45, 1'b1, 4'h9, 1'b0, 1'b1, 3'd0};

    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_hamming_code = '0; bus.i_parity = 1'b0;
    bus.i_ready = 1'b0; bus.i_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_data", bus.o_data, 0);
    check("rst_flags", {bus.o_single_err, bus.o_double_err}, 0);
    check("rst_err_pos", bus.o_err_pos, 0);
    check("rst_cnts", {bus.o_sec_cnt, bus.o_ded_cnt}, 0);
    check("rst_o_ready", bus.o_ready, 1);

    // Directed table, one word at a time with no backpressure.
    exp_sec = 0; exp_ded = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b1; bus.i_hamming_code = vecs[i].code; bus.i_parity = vecs[i].par;
      bus.i_ready = 1'b1;
      #1 check($sformatf("vec%0d_ready", i), bus.o_ready, 1);
      @(negedge clk);
      bus.i_valid = 1'b0;
      check($sformatf("vec%0d_lat1", i), bus.o_valid, 0);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), bus.o_valid, 1);
      check($sformatf("vec%0d_data", i), bus.o_data, vecs[i].data);
      check($sformatf("vec%0d_sec", i), bus.o_single_err, vecs[i].sec);
      check($sformatf("vec%0d_ded", i), bus.o_double_err, vecs[i].ded);
      check($sformatf("vec%0d_pos", i), bus.o_err_pos, vecs[i].pos);
      if (vecs[i].sec) exp_sec = sat3(exp_sec);
      if (vecs[i].ded) exp_ded = sat3(exp_ded);
      @(negedge clk);
      check($sformatf("vec%0d_sec_cnt", i), bus.o_sec_cnt, exp_sec);
      check($sformatf("vec%0d_ded_cnt", i), bus.o_ded_cnt, exp_ded);
    end

    // Backpressure: three back-to-back offers with the sink stalled.
    begin
      logic [6:0] bp_code[3];
      logic       bp_par[3];
      logic [3:0] bp_data[3];
      int acc, got;
      logic tk_in, tk_out;
      bp_code[0] = 7'h55; bp_par[0] = 1'b0; bp_data[0] = 4'hB;
      bp_code[1] = 7'h00; bp_par[1] = 1'b0; bp_data[1] = 4'h0;
      bp_code[2] = 7'h7F; bp_par[2] = 1'b1; bp_data[2] = 4'hF;
      acc = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
        @(negedge clk);
        bus.i_ready = 1'b0;
        bus.i_valid = (acc < 3);
        if (acc < 3) begin
          bus.i_hamming_code = bp_code[acc]; bus.i_parity = bp_par[acc];
        end
        #1 tk_in = bus.i_valid & bus.o_ready;
        @(posedge clk);
        if (tk_in) acc++;
      end
      @(negedge clk);
      check("bp_accepted", acc, 2);
      check("bp_o_ready", bus.o_ready, 0);
      check("bp_o_valid", bus.o_valid, 1);
      for (int k = 0; k < 3; k++) begin
        check("bp_hold_data", bus.o_data, 4'hB);
        check("bp_hold_flags", {bus.o_single_err, bus.o_double_err, bus.o_err_pos}, 0);
        @(negedge clk);
      end
      got = 0;
      for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
        if (cyc != 0) @(negedge clk);
        bus.i_ready = 1'b1;
        bus.i_valid = (acc < 3);
        if (acc < 3) begin
          bus.i_hamming_code = bp_code[acc]; bus.i_parity = bp_par[acc];
        end
        #1;
        tk_in  = bus.i_valid & bus.o_ready;
        tk_out = bus.o_valid & bus.i_ready;
        if (tk_out) begin
          check($sformatf("bp_order%0d", got), bus.o_data, bp_data[got]);
          got++;
        end
        @(posedge clk);
        if (tk_in) acc++;
      end
      check("bp_drained", got, 3);
      @(negedge clk);
      bus.i_valid = 1'b0;
    end

    // Reset with a word in flight discards it and zeroes the counters.
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_hamming_code = 7'h45; bus.i_parity = 1'b0; bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_o_valid", bus.o_valid, 0);
    check("midrst_sec_cnt", bus.o_sec_cnt, 0);
    check("midrst_ded_cnt", bus.o_ded_cnt, 0);
    check("midrst_o_ready", bus.o_ready, 1);
    repeat (3) @(negedge clk);
    check("midrst_no_ghost", {bus.o_valid, bus.o_sec_cnt}, 0);

    // Saturation: five single-error words into a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b1; bus.i_hamming_code = 7'h45; bus.i_parity = 1'b0; bus.i_ready = 1'b1;
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_sec_cnt", bus.o_sec_cnt, 3);
    check("sat_ded_cnt", bus.o_ded_cnt, 0);

    // Clear coinciding with a single-error output transfer.
    bus.i_valid = 1'b1; bus.i_hamming_code = 7'h45; bus.i_parity = 1'b0;
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("clr_o_valid", bus.o_valid, 1);
    bus.i_cnt_clr = 1'b1;
    @(negedge clk);
    bus.i_cnt_clr = 1'b0;
    check("clr_wins_sec", bus.o_sec_cnt, 0);
    check("clr_after_xfer", bus.o_valid, 0);

    // Randomized traffic with random stalls against the reference model.
    begin
      exp_t q[$];
      exp_t e, pv;
      logic prev_hold, tk_in, tk_out;
      logic [3:0] d;
      logic [7:0] mask;
      logic [6:0] code;
      int nflip, ms, md;
      ms = 0; md = 0; prev_hold = 1'b0;
      pv = '{4'h0, 1'b0, 1'b0, 3'd0};
      for (int cyc = 0; cyc < 420; cyc++) begin
        @(negedge clk);
        check("rnd_sec_cnt", bus.o_sec_cnt, ms);
        check("rnd_ded_cnt", bus.o_ded_cnt, md);
        if (prev_hold) begin
          check("rnd_hold_valid", bus.o_valid, 1);
          check("rnd_hold_out", {bus.o_data, bus.o_single_err, bus.o_double_err, bus.o_err_pos},
                {pv.data, pv.sec, pv.ded, pv.pos});
        end
        if (cyc >= 400) begin
          if (q.size() == 0) break;
          bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        end else begin
          bus.i_ready = ($urandom_range(0, 3) != 0);
          bus.i_valid = $urandom_range(0, 1) != 0;
        end
        d = 4'($urandom_range(0, 15));
        nflip = $urandom_range(0, 2);
        mask = '0;
        while ($countones(mask) < nflip) mask[$urandom_range(0, 7)] = 1'b1;
        code = encode(d) ^ mask[6:0];
        bus.i_hamming_code = code;
        bus.i_parity = (^encode(d)) ^ mask[7];
        #1;
        check("rnd_o_ready", bus.o_ready, (q.size() < 2) || bus.i_ready);
        check("rnd_excl_flags", bus.o_single_err & bus.o_double_err, 0);
        tk_in  = bus.i_valid & bus.o_ready;
        tk_out = bus.o_valid & bus.i_ready;
        if (tk_out) begin
          if (q.size() == 0) check("rnd_spurious", bus.o_valid, 0);
          else begin
            e = q.pop_front();
            check("rnd_data", bus.o_data, e.data);
            check("rnd_flags", {bus.o_single_err, bus.o_double_err}, {e.sec, e.ded});
            check("rnd_pos", bus.o_err_pos, e.pos);
            if (e.sec) ms = sat3(ms);
            if (e.ded) md = sat3(md);
          end
        end
        if (tk_in) q.push_back(classify(d, mask, code));
        prev_hold = bus.o_valid & ~bus.i_ready;
        pv = '{bus.o_data, bus.o_single_err, bus.o_double_err, bus.o_err_pos};
      end
      check("rnd_drain_empty", q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hamming74_secded_dec.md
HAMMING74_SECDED_DEC -- requirements
Module: hamming74_secded_dec

Interface
REQ-001 Parameter CNT_W, default 16, width of each error counter.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_valid  input  1  upstream word valid.
REQ-006 o_ready  output  1  block can accept a word this cycle.
REQ-007 i_hamming_code  input  7  code word {d3,d2,d1,p4,d0,p2,p1}; bit k is Hamming position k+1.
REQ-008 i_parity  input  1  overall even parity over the 7 code bits.
REQ-009 o_valid  output  1  decoded word valid.
REQ-010 i_ready  input  1  downstream accepts the word this cycle.
REQ-011 o_data  output  4  decoded data {d3,d2,d1,d0}.
REQ-012 o_single_err  output  1  single error detected and corrected.
REQ-013 o_double_err  output  1  double error detected; data uncorrected.
REQ-014 o_err_pos  output  3  corrected Hamming position 1-7; 0 = overall parity bit or no error.
REQ-015 i_cnt_clr  input  1  synchronous clear of both counters.
REQ-016 o_sec_cnt  output  CNT_W  saturating count of single-error words delivered.
REQ-017 o_ded_cnt  output  CNT_W  saturating count of double-error words delivered.

Function
REQ-018 Stage 1 SHALL compute s1 = c0^c2^c4^c6, s2 = c1^c2^c5^c6, s4 = c3^c4^c5^c6, S = {s4,s2,s1}, and P = (^c)^i_parity; it registers the code word, S and P.
REQ-019 Stage 2 SHALL classify and register the results:
- S=0, P=0: clean; o_data = {c6,c5,c4,c2}; both error flags 0; o_err_pos=0.
- S!=0, P=1: invert code bit S-1; o_data taken from the corrected word; o_single_err=1; o_err_pos=S.
- S=0, P=1: parity-bit error; data unchanged; o_single_err=1; o_err_pos=0.
- S!=0, P=0: o_data = raw {c6,c5,c4,c2}; o_double_err=1; o_err_pos=0.
REQ-020 o_single_err and o_double_err SHALL never both be 1.
REQ-021 An input transfer occurs when i_valid & o_ready at a rising edge. An output transfer occurs when o_valid & i_ready at a rising edge.
REQ-022 Handshake rules:
- Stage 2 SHALL load when it is empty or i_ready=1.
- Stage 1 SHALL advance into stage 2 under the same condition.
- o_ready = ~v1 | ~v2 | i_ready, where v1 and v2 are the stage valid bits. o_ready is combinational from state and i_ready only.
REQ-023 Latency: a word accepted at edge k SHALL present o_valid=1 from edge k+2 when there is no backpressure. Full throughput is one word per cycle.
REQ-024 Output stability: while o_valid=1 and i_ready=0, all o_data, flag and o_err_pos outputs SHALL hold stable. Stage 1 holds one additional word. After both stages are full, o_ready=0.
REQ-025 Ordering: words SHALL exit in acceptance order, with none dropped or duplicated.
REQ-026 Counters SHALL update on an output transfer:
- o_sec_cnt increments when o_single_err=1.
- o_ded_cnt increments when o_double_err=1.
- Each counter saturates at 2^CNT_W-1 and does not wrap.
REQ-027 i_cnt_clr=1 SHALL zero both counters at the edge; if clear and an increment occur in the same cycle, the clear wins.

Reset
REQ-028 While i_rst=1 at an edge, the block SHALL clear v1, v2, o_valid, o_data, o_single_err, o_double_err, o_err_pos, o_sec_cnt and o_ded_cnt to 0. o_ready is 1 in the first cycle after reset.
REQ-029 Reset mid-operation SHALL discard in-flight words without a counter increment. Reset overrides i_cnt_clr and all handshakes.

Verification
REQ-030 Clean word: code 0x55, parity 0, i_ready=1 -> two cycles later o_valid=1, o_data=0xB, both flags 0, o_err_pos=0; counters unchanged.
REQ-031 Single data error: code 0x45, parity 0 -> o_data=0xB, o_single_err=1, o_err_pos=5; o_sec_cnt increments by 1.
REQ-032 Double error: code 0x56, parity 0 -> o_double_err=1, o_single_err=0, o_data=0xB (raw), o_err_pos=0; o_ded_cnt increments by 1.
REQ-033 Parity-bit error: code 0x55, parity 1 -> o_data=0xB, o_single_err=1, o_err_pos=0.
REQ-034 Backpressure: hold i_ready=0 and offer 3 back-to-back words -> 2 words accepted, then o_ready=0 and outputs stable. Raising i_ready then delivers the words in order with no loss.
REQ-035 Counter edges: preload (or with CNT_W=2) drive 5 single-error words -> o_sec_cnt saturates at 3. Assert i_cnt_clr together with a single-error output transfer -> counter reads 0. Assert i_rst with a word in flight -> o_valid=0 the next cycle and counters=0.
